dmem_stage: RTL and testbench

Parametrised data-memory stage for the CPU datapath, sitting between the execute stage (ALU result, store operand) and writeback. It performs byte, halfword and word loads/stores with sign or zero extension, flags misaligned accesses, and models slow memory through a configurable wait-state counter with a valid/ready handshake. It also resolves the branch decision (`pcsrc`) and delivers it registered alongside the load result.

---
 rtl/dmem_pkg.sv | 72 +++++++
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_stage.sv | 151 +++++++++++++++
 tb/tb_dmem_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory stage.
//   size_e   : access size encoding as seen on the size input (3 folds to word)
//   state_e  : handshake FSM states
//   op_t     : fields captured from the execute stage at accept
//   helpers  : size normalisation, misalignment test, byte enables,
//              store lane replication, load lane extract + extend
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]  lane;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        size_e       sz;
        logic        uns;
        logic        pc;
        logic        mis;
    } op_t;

    function automatic size_e norm_size(input logic [1:0] s);
        return (s == 2'd3) ? SZ_W : size_e'(s);
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_H:    return lane[0];
            SZ_W:    return lane != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_B:    return 4'b0001 << lane;
            SZ_H:    return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the low bytes across the word so any enabled lane sees them.
    function automatic logic [31:0] store_lanes(input size_e sz, input logic [31:0] d);
        case (sz)
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input size_e sz,
                                                input logic [1:0] lane, input logic uns);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (sz)
            SZ_B:    return {{24{~uns & sh[7]}}, sh[7:0]};
            SZ_H:    return {{16{~uns & sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 synchronous RAM.
//   clk   : clock
//   en    : access strobe; write lanes and registered read happen on this edge
//   addr  : word index
//   we    : per-byte write enables
//   wdata : write data (lane-aligned)
//   rdata : registered read data (old contents on a simultaneous write)
// Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_stage.sv
// Data-memory stage between execute and writeback.
//   in_valid/in_ready  : op handshake from execute (accept when both high)
//   alu_out            : byte address; store_data : store operand
//   mem_write/mem_read : op kind; size/ld_unsigned : access width and extension
//   branch/zero        : branch resolution inputs
//   out_valid          : one-cycle result pulse
//   read_data/pcsrc/misaligned : result fields, 0 whenever out_valid is low
module dmem_stage
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic              branch,
    input  logic              zero,
    output logic              out_valid,
    output logic [DATA_W-1:0] read_data,
    output logic              pcsrc,
    output logic              misaligned
);

    localparam int AW = $clog2(DEPTH);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    op_t           op_q, op_d;
    logic [AW-1:0] idx_q, idx_d;

    logic          accept;
    logic          in_mem;
    size_e         in_sz;
    logic          in_mis;

    logic          mem_en;
    logic [AW-1:0] mem_idx;
    logic [3:0]    mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    // Upper address bits wrap away; some op fields only feed the WAIT commit path.
    logic unused_addr_bits;
    logic unused_op_bits;
    assign unused_addr_bits = ^alu_out[DATA_W-1:AW+2];
    assign unused_op_bits   = ^{op_q.wdata, op_q.we, idx_q};

    assign accept = in_valid && (state_q == IDLE);
    assign in_mem = mem_read || mem_write;
    assign in_sz  = norm_size(size);
    assign in_mis = in_mem && is_misaligned(in_sz, alu_out[1:0]);

    always_comb begin
        op_d  = op_q;
        idx_d = idx_q;
        if (accept) begin
            op_d.lane  = alu_out[1:0];
            op_d.wdata = store_data;
            op_d.we    = mem_write;
            op_d.re    = mem_read;
            op_d.sz    = in_sz;
            op_d.uns   = ld_unsigned;
            op_d.pc    = branch && zero;
            op_d.mis   = in_mis;
            idx_d      = alu_out[2 +: AW];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_mem && (WAIT_CYCLES > 0)) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With no wait states the array must be hit on the accept edge itself, so
    // it is driven straight from the inputs; otherwise from the op register on
    // the edge that leaves WAIT (a reset in WAIT therefore drops the store).
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            mem_en    = accept && in_mem;
            mem_idx   = alu_out[2 +: AW];
            mem_we    = (mem_write && !in_mis) ? byte_en(in_sz, alu_out[1:0]) : '0;
            mem_wdata = store_lanes(in_sz, store_data);
        end else begin
            mem_en    = (state_q == WAIT) && (cnt_q == '0);
            mem_idx   = idx_q;
            mem_we    = (op_q.we && !op_q.mis) ? byte_en(op_q.sz, op_q.lane) : '0;
            mem_wdata = store_lanes(op_q.sz, op_q.wdata);
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (mem_en),
        .addr  (mem_idx),
        .we    (mem_we),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == RESP);
    assign pcsrc      = out_valid && op_q.pc;
    assign misaligned = out_valid && op_q.mis;
    assign read_data  = (out_valid && op_q.re && !op_q.we && !op_q.mis)
                        ? load_extend(mem_rdata, op_q.sz, op_q.lane, op_q.uns) : '0;

endmodule

// File: tb/tb_dmem_stage.sv
// Bench for dmem_stage: two instances (no wait states / DEPTH 256, and three
// wait states / DEPTH 16) fed the same ops, each checked every cycle against a
// transaction-level model, plus literal expectations for the directed cases.
module tb_dmem_stage;

    localparam int DEP0 = 256;
    localparam int DEP1 = 16;
    localparam int W1   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  v = 2'b00;
    logic [31:0] a = '0, sd = '0;
    logic        mw = 1'b0, mr = 1'b0, uns = 1'b0, br = 1'b0, zf = 1'b0;
    logic [1:0]  sz = 2'd0;

    logic        rdy [2];
    logic        ov  [2];
    logic [31:0] rd  [2];
    logic        pc  [2];
    logic        mis [2];

    dmem_stage #(.DATA_W(32), .DEPTH(DEP0), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_ready(rdy[0]),
        .alu_out(a), .store_data(sd), .mem_write(mw), .mem_read(mr),
        .size(sz), .ld_unsigned(uns), .branch(br), .zero(zf),
        .out_valid(ov[0]), .read_data(rd[0]), .pcsrc(pc[0]), .misaligned(mis[0]));

    dmem_stage #(.DATA_W(32), .DEPTH(DEP1), .WAIT_CYCLES(W1)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_ready(rdy[1]),
        .alu_out(a), .store_data(sd), .mem_write(mw), .mem_read(mr),
        .size(sz), .ld_unsigned(uns), .branch(br), .zero(zf),
        .out_valid(ov[1]), .read_data(rd[1]), .pcsrc(pc[1]), .misaligned(mis[1]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d: got %h expected %h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mm0 [DEP0];
    logic [31:0] mm1 [DEP1];
    int          m_rem   [2] = '{0, 0};   // cycles until ready again; 1 = response cycle
    int          acc_seq [2] = '{-1, -1};
    int          acc_cyc [2] = '{0, 0};
    int          op_seq = 0;
    int          cyc = 0;
    logic [31:0] o_a [2], o_sd [2];
    logic        o_w [2], o_r [2], o_u [2];
    logic [1:0]  o_sz [2];
    logic [31:0] e_rd [2];
    logic        e_pc [2], e_mis [2];

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic f_mis(input logic [1:0] s, input logic [31:0] ad, input logic w, input logic r);
        if (!(w || r)) return 1'b0;
        if (s == 2'd1) return (ad % 2) != 0;
        if (s >= 2'd2) return (ad % 4) != 0;
        return 1'b0;
    endfunction

    task automatic commit(input int k);
        int idx, n, lane;
        logic [31:0] word, res, mask;
        lane = int'(o_a[k] % 4);
        n    = nbytes(o_sz[k]);
        idx  = int'((o_a[k] / 4) % ((k == 0) ? DEP0 : DEP1));
        word = (k == 0) ? mm0[idx] : mm1[idx];
        if (!e_mis[k]) begin
            if (o_w[k]) begin
                for (int b = 0; b < n; b++) word[8*(lane+b) +: 8] = o_sd[k][8*b +: 8];
                if (k == 0) mm0[idx] = word; else mm1[idx] = word;
            end else if (o_r[k]) begin
                res = word >> (8 * lane);
                if (n < 4) begin
                    mask = (32'd1 << (8 * n)) - 32'd1;
                    res  = res & mask;
                    if (!o_u[k] && res[8*n-1]) res = res | ~mask;
                end
                e_rd[k] = res;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) m_rem[k] = 0;
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (m_rem[k] == 0) begin
                    if (v[k]) begin
                        int lat;
                        o_a[k] = a; o_sd[k] = sd; o_w[k] = mw; o_r[k] = mr;
                        o_u[k] = uns; o_sz[k] = sz;
                        e_rd[k]  = '0;
                        e_pc[k]  = br && zf;
                        e_mis[k] = f_mis(sz, a, mw, mr);
                        lat = ((mw || mr) && k == 1) ? W1 : 0;
                        m_rem[k]   = lat + 1;
                        acc_seq[k] = op_seq;
                        acc_cyc[k] = cyc;
                        if (lat == 0 && (mw || mr)) commit(k);
                    end
                end else begin
                    if (m_rem[k] == 2) commit(k);
                    m_rem[k]--;
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    logic [31:0] last_rd [2];
    logic        last_pc [2], last_mis [2];
    int          dut_lat [2], busy_cnt [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic exp_ov;
            exp_ov = (m_rem[k] == 1);
            chk("in_ready", k, 32'(rdy[k]), 32'(m_rem[k] == 0));
            chk("out_valid", k, 32'(ov[k]), 32'(exp_ov));
            chk("read_data", k, rd[k], exp_ov ? e_rd[k] : 32'd0);
            chk("pcsrc", k, 32'(pc[k]), exp_ov ? 32'(e_pc[k]) : 32'd0);
            chk("misaligned", k, 32'(mis[k]), exp_ov ? 32'(e_mis[k]) : 32'd0);
            if (!rdy[k]) busy_cnt[k]++;
            if (ov[k]) begin
                last_rd[k]  = rd[k];
                last_pc[k]  = pc[k];
                last_mis[k] = mis[k];
                dut_lat[k]  = cyc - acc_cyc[k] + 1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic start(input logic [31:0] ad, input logic [31:0] d, input logic w, input logic r,
                         input logic [1:0] s, input logic u, input logic b, input logic z);
        @(negedge clk); #1;
        op_seq++;
        a = ad; sd = d; mw = w; mr = r; sz = s; uns = u; br = b; zf = z;
        for (int k = 0; k < 2; k++) begin
            last_rd[k] = 'x; last_pc[k] = 1'bx; last_mis[k] = 1'bx;
            dut_lat[k] = -1; busy_cnt[k] = 0;
        end
        v = 2'b11;
    endtask

    // hold: keep in_valid up through the whole busy period after accept.
    task automatic finish_op(input bit hold);
        int budget;
        budget = 60;
        forever begin
            @(negedge clk); #1;
            for (int k = 0; k < 2; k++)
                if (v[k] && acc_seq[k] == op_seq &&
                    (m_rem[k] <= 1 || (!hold && $urandom_range(0, 1) == 1)))
                    v[k] = 1'b0;
            if (v == 2'b00 && m_rem[0] == 0 && m_rem[1] == 0) break;
            budget--;
            if (budget == 0) begin
                checks++; errors++;
                $display("FAIL op_timeout: op %0d not retired, got rem %0d/%0d expected 0/0",
                         op_seq, m_rem[0], m_rem[1]);
                v = 2'b00;
                break;
            end
        end
    endtask

    task automatic do_op(input logic [31:0] ad, input logic [31:0] d, input logic w, input logic r,
                         input logic [1:0] s, input logic u, input logic b, input logic z);
        start(ad, d, w, r, s, u, b, z);
        finish_op(1'b1);
    endtask

    task automatic expect_rd(input string name, input logic [31:0] e0, input logic [31:0] e1);
        chk({name, "_rd"}, 0, last_rd[0], e0);
        chk({name, "_rd"}, 1, last_rd[1], e1);
        chk({name, "_model"}, 0, e_rd[0], e0);
        chk({name, "_model"}, 1, e_rd[1], e1);
    endtask

    initial begin
        #1;
        chk("reset_in_ready", 0, 32'(rdy[0]), 32'd1);
        chk("reset_in_ready", 1, 32'(rdy[1]), 32'd1);
        chk("reset_out_valid", 0, 32'(ov[0]), 32'd0);
        chk("reset_read_data", 1, rd[1], 32'd0);
        @(negedge clk); @(negedge clk); #1;
        rst_n = 1'b1;

        // fill every word so later loads have defined contents
        for (int i = 0; i < DEP0; i++) begin
            start(32'(4 * i), $urandom, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
            finish_op(1'b0);
        end

        // word round-trip and latency
        do_op(32'h10, 32'hDEADBEEF, 1, 0, 2'd2, 0, 0, 0);
        do_op(32'h10, 32'h0, 0, 1, 2'd2, 0, 0, 0);
        expect_rd("word_rt", 32'hDEADBEEF, 32'hDEADBEEF);
        chk("latency", 0, 32'(dut_lat[0]), 32'd1);
        chk("latency", 1, 32'(dut_lat[1]), 32'd4);
        chk("busy_cycles", 0, 32'(busy_cnt[0]), 32'd1);
        chk("busy_cycles", 1, 32'(busy_cnt[1]), 32'd4);

        // extension
        do_op(32'h13, 32'h0, 0, 1, 2'd0, 0, 0, 0);
        expect_rd("lb_signed", 32'hFFFFFFDE, 32'hFFFFFFDE);
        do_op(32'h12, 32'h0, 0, 1, 2'd1, 1, 0, 0);
        expect_rd("lhu", 32'h0000DEAD, 32'h0000DEAD);
        do_op(32'h11, 32'h55, 1, 0, 2'd0, 0, 0, 0);
        do_op(32'h10, 32'h0, 0, 1, 2'd2, 0, 0, 0);
        expect_rd("sb_merge", 32'hDEAD55EF, 32'hDEAD55EF);

        // misalignment
        do_op(32'h20, 32'h12345678, 1, 0, 2'd2, 0, 0, 0);
        do_op(32'h22, 32'hFFFFFFFF, 1, 0, 2'd2, 0, 0, 0);
        chk("sw_mis_flag", 0, 32'(last_mis[0]), 32'd1);
        chk("sw_mis_flag", 1, 32'(last_mis[1]), 32'd1);
        do_op(32'h20, 32'h0, 0, 1, 2'd2, 0, 0, 0);
        expect_rd("sw_mis_nowrite", 32'h12345678, 32'h12345678);
        do_op(32'h21, 32'h0, 0, 1, 2'd1, 0, 0, 0);
        expect_rd("lh_mis", 32'h0, 32'h0);
        chk("lh_mis_flag", 0, 32'(last_mis[0]), 32'd1);
        chk("lh_mis_flag", 1, 32'(last_mis[1]), 32'd1);

        // branch resolution; non-memory ops are single-cycle even with wait states
        do_op(32'h0, 32'h0, 0, 0, 2'd0, 0, 1, 1);
        chk("pcsrc_taken", 0, 32'(last_pc[0]), 32'd1);
        chk("pcsrc_taken", 1, 32'(last_pc[1]), 32'd1);
        chk("nonmem_latency", 1, 32'(dut_lat[1]), 32'd1);
        do_op(32'h0, 32'h0, 0, 0, 2'd0, 0, 1, 0);
        chk("pcsrc_not_taken", 0, 32'(last_pc[0]), 32'd0);
        chk("pcsrc_not_taken", 1, 32'(last_pc[1]), 32'd0);

        // reset during WAIT of a store
        do_op(32'h30, 32'h11111111, 1, 0, 2'd2, 0, 0, 0);
        start(32'h30, 32'hCAFEF00D, 1, 0, 2'd2, 0, 0, 0);
        for (int i = 0; i < 10 && m_rem[1] != 2; i++) begin
            @(negedge clk); #1;
            for (int k = 0; k < 2; k++) if (acc_seq[k] == op_seq && m_rem[k] <= 1) v[k] = 1'b0;
        end
        chk("reached_wait", 1, 32'(m_rem[1]), 32'd2);
        v = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", 1, 32'(rdy[1]), 32'd1);
        chk("rst_mid_valid", 1, 32'(ov[1]), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        do_op(32'h30, 32'h0, 0, 1, 2'd2, 0, 0, 0);
        expect_rd("rst_store_dropped", 32'hCAFEF00D, 32'h11111111);

        // address wrap
        do_op(32'h408, 32'hA5A50408, 1, 0, 2'd2, 0, 0, 0);
        do_op(32'h8, 32'h0, 0, 1, 2'd2, 0, 0, 0);
        expect_rd("wrap", 32'hA5A50408, 32'hA5A50408);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ad;
            ad = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            start(ad, $urandom, 1'($urandom), 1'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            finish_op(1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
